// File: rtl/mmio_led_pwm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmio_led_pwm                                                             |
// | Memory-mapped multi-channel LED PWM controller on the 8-bit CPU bus:     |
// | per-channel enable, frame-synchronous duty shadowing, shared prescaler.  |
// | Optional blink engine built only when LED_PWM_BLINK_EN is defined.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mmio_led_pwm #(
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned PWM_BITS  = 8,
  parameter logic [7:0]  BASE_ADDR = 8'd128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write,
  input  logic                read,
  input  logic [7:0]          address,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  output logic [CHANNELS-1:0] led_n
);

  localparam logic [7:0]          OFF_CTRL     = 8'd0;
  localparam logic [7:0]          OFF_PRESCALE = 8'd1;
  localparam logic [7:0]          OFF_DUTY0    = 8'd3;
  localparam logic [PWM_BITS-1:0] DUTY_MAX     = '1;

  // Address decode
  logic [7:0] offset;
  logic       in_window;
  logic       wr_ctrl;
  logic       wr_prescale;

  assign offset      = address - BASE_ADDR;
  assign in_window   = (address >= BASE_ADDR);
  assign wr_ctrl     = write && in_window && (offset == OFF_CTRL);
  assign wr_prescale = write && in_window && (offset == OFF_PRESCALE);

  // Register state
  logic [CHANNELS-1:0] ctrl_q,     ctrl_d;
  logic [7:0]          prescale_q, prescale_d;
  logic [7:0]          pre_cnt_q,  pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
  logic [PWM_BITS-1:0] shadow_q [CHANNELS];
  logic [PWM_BITS-1:0] shadow_d [CHANNELS];
  logic [PWM_BITS-1:0] active_q [CHANNELS];
  logic [PWM_BITS-1:0] active_d [CHANNELS];
  logic [CHANNELS-1:0] led_n_q,    led_n_d;
  logic [7:0]          rdata_q,    rdata_d;
  logic [7:0]          rd_val;

  logic tick;
  logic frame_wrap;
  logic blink_visible;

  assign tick       = (pre_cnt_q == prescale_q);
  assign frame_wrap = tick && (pwm_cnt_q == DUTY_MAX);

`ifdef LED_PWM_BLINK_EN
  localparam logic [7:0] OFF_BLINK = 8'd2;

  logic       wr_blink;
  logic [7:0] blink_q,     blink_d;
  logic [6:0] frame_cnt_q, frame_cnt_d;
  logic       phase_q,     phase_d;

  assign wr_blink = write && in_window && (offset == OFF_BLINK);

  always_comb begin
    blink_d     = blink_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (wr_blink) begin
      blink_d     = wdata;
      frame_cnt_d = 7'd0;
      phase_d     = 1'b0;
    end else if (blink_q[7] && frame_wrap) begin
      if (frame_cnt_q == blink_q[6:0]) begin
        frame_cnt_d = 7'd0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q     <= 8'd0;
      frame_cnt_q <= 7'd0;
      phase_q     <= 1'b0;
    end else begin
      blink_q     <= blink_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Phase 1 blanks every channel, but only while blinking is enabled
  assign blink_visible = !(blink_q[7] && phase_q);
`else
  assign blink_visible = 1'b1;
`endif

  // Control registers, prescaler, PWM counter and per-channel outputs
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    led_n_d    = led_n_q;

    if (wr_ctrl) begin
      ctrl_d = wdata[CHANNELS-1:0];
    end
    if (wr_prescale) begin
      prescale_d = wdata;
    end

    if (tick || wr_prescale) begin
      pre_cnt_d = 8'd0;
    end else begin
      pre_cnt_d = pre_cnt_q + 8'd1;
    end

    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    for (int i = 0; i < int'(CHANNELS); i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (write && in_window && (offset == OFF_DUTY0 + 8'(i))) begin
        shadow_d[i] = wdata[PWM_BITS-1:0];
      end
      // Old shadow is taken, so a write on the boundary cycle waits a frame
      if (frame_wrap) begin
        active_d[i] = shadow_q[i];
      end
      led_n_d[i] = ~(ctrl_q[i] &&
                     ((active_q[i] == DUTY_MAX) || (pwm_cnt_q < active_q[i])) &&
                     blink_visible);
    end
  end

  // Read path
  always_comb begin
    rd_val = 8'd0;
    if (in_window) begin
      if (offset == OFF_CTRL) begin
        rd_val = 8'(ctrl_q);
      end
      if (offset == OFF_PRESCALE) begin
        rd_val = prescale_q;
      end
`ifdef LED_PWM_BLINK_EN
      if (offset == OFF_BLINK) begin
        rd_val = blink_q;
      end
`endif
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (offset == OFF_DUTY0 + 8'(i)) begin
          rd_val = 8'(shadow_q[i]);
        end
      end
    end
    // A colliding write wins; the read returns 0
    rdata_d = (read && !write) ? rd_val : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= 8'd0;
      pre_cnt_q  <= 8'd0;
      pwm_cnt_q  <= '0;
      led_n_q    <= '1;
      rdata_q    <= 8'd0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        shadow_q[i] <= DUTY_MAX;
        active_q[i] <= DUTY_MAX;
      end
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_n_q    <= led_n_d;
      rdata_q    <= rdata_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  assign rdata = rdata_q;
  assign led_n = led_n_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_led_pwm.sv
`default_nettype none
// Testbench for mmio_led_pwm: register model plus frame-level on-time counting.
module tb_mmio_led_pwm;

  localparam int         CH    = 3;
  localparam int         PW    = 8;
  localparam logic [7:0] BASE  = 8'd128;
  localparam int         FULL  = (1 << PW) - 1;
`ifdef LED_PWM_BLINK_EN
  localparam bit         BLINK_BUILT = 1'b1;
`else
  localparam bit         BLINK_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic          read;
  logic [7:0]    address;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic [CH-1:0] led_n;

  int n_checks = 0;
  int n_fail   = 0;

  int m_ctrl;
  int m_pre;
  int m_blink;
  int m_duty [CH];

  always #5 clk = ~clk;

  mmio_led_pwm #(
    .CHANNELS (CH),
    .PWM_BITS (PW),
    .BASE_ADDR(BASE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .write  (write),
    .read   (read),
    .address(address),
    .wdata  (wdata),
    .rdata  (rdata),
    .led_n  (led_n)
  );

  task automatic model_reset();
    m_ctrl  = 0;
    m_pre   = 0;
    m_blink = 0;
    for (int i = 0; i < CH; i++) m_duty[i] = FULL;
  endtask

  function automatic int model_read(input int a);
    int off;
    off = a - int'(BASE);
    if (off == 0) return m_ctrl;
    if (off == 1) return m_pre;
    if (off == 2) return BLINK_BUILT ? m_blink : 0;
    if (off >= 3 && off < 3 + CH) return m_duty[off-3];
    return 0;
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    write = 1'b1; address = a; wdata = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    read = 1'b1; address = a;
    @(negedge clk);
    read = 1'b0;
    d = rdata;
  endtask

  task automatic reg_write(input int a, input int d);
    int off;
    off = a - int'(BASE);
    bus_write(8'(a), 8'(d));
    if (off == 0) m_ctrl = d % (1 << CH);
    else if (off == 1) m_pre = d % 256;
    else if (off == 2 && BLINK_BUILT) m_blink = d % 256;
    else if (off >= 3 && off < 3 + CH) m_duty[off-3] = d % (1 << PW);
  endtask

  task automatic wait_fall(input int ch, output bit ok);
    logic prev;
    ok = 1'b0;
    @(negedge clk);
    prev = led_n[ch];
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (prev === 1'b1 && led_n[ch] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = led_n[ch];
    end
  endtask

  // Counts consecutive samples equal to lvl, starting with the current one
  task automatic run_length(input int ch, input logic lvl, output int run);
    run = 1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (led_n[ch] !== lvl) break;
      run++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int exp;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (led_n !== 3'b111) begin
      n_fail++; $display("FAIL reset_led: got %b expected %b", led_n, 3'b111);
    end
    n_checks++;
    if (rdata !== 8'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata);
    end
    rst = 1'b0;
    model_reset();
    for (int a = int'(BASE); a < int'(BASE) + 3 + CH; a++) begin
      bus_read(8'(a), d);
      exp = model_read(a);
      n_checks++;
      if (d !== exp[7:0]) begin
        n_fail++; $display("FAIL reset_reg[%0d]: got %h expected %h", a, d, exp[7:0]);
      end
    end
  endtask

  task automatic test_ctrl_enable();
    logic [7:0] d;
    reg_write(BASE, 8'h05);
    n_checks++;
    if (led_n !== 3'b111) begin
      n_fail++; $display("FAIL ctrl_lag: got %b expected %b", led_n, 3'b111);
    end
    @(negedge clk);
    n_checks++;
    if (led_n !== 3'b010) begin
      n_fail++; $display("FAIL ctrl_led: got %b expected %b", led_n, 3'b010);
    end
    bus_read(BASE, d);
    n_checks++;
    if (d !== 8'h05) begin
      n_fail++; $display("FAIL ctrl_read: got %h expected 05", d);
    end
    @(negedge clk);
    n_checks++;
    if (rdata !== 8'h00) begin
      n_fail++; $display("FAIL rdata_idle: got %h expected 00", rdata);
    end
  endtask

  // Over any window of one frame the LED is on for exactly duty*(P+1) cycles
  task automatic test_duty(input int ch, input int duty, input int p);
    int frame, lows, others, exp;
    logic [7:0] d;
    reg_write(BASE + 1, p);
    reg_write(BASE + 0, 1 << ch);
    reg_write(BASE + 3 + ch, duty);
    frame = (p + 1) * (1 << PW);
    repeat (frame + 4) @(negedge clk);
    lows = 0;
    others = 0;
    repeat (frame) begin
      @(negedge clk);
      if (led_n[ch] === 1'b0) lows++;
      for (int j = 0; j < CH; j++) if (j != ch && led_n[j] !== 1'b1) others++;
    end
    exp = (duty == FULL) ? frame : duty * (p + 1);
    n_checks++;
    if (lows !== exp) begin
      n_fail++;
      $display("FAIL duty_on_time ch%0d duty %0d pre %0d: got %0d expected %0d",
               ch, duty, p, lows, exp);
    end
    n_checks++;
    if (others !== 0) begin
      n_fail++; $display("FAIL disabled_off: got %0d lit samples expected 0", others);
    end
    bus_read(8'(int'(BASE) + 3 + ch), d);
    exp = model_read(int'(BASE) + 3 + ch);
    n_checks++;
    if (d !== exp[7:0]) begin
      n_fail++; $display("FAIL duty_read ch%0d: got %h expected %h", ch, d, exp[7:0]);
    end
  endtask

  task automatic test_shadow();
    bit ok, hi_seen;
    int run;
    logic [7:0] d;
    reg_write(BASE + 1, 0);
    reg_write(BASE + 4, 128);
    reg_write(BASE + 0, 2);
    repeat (600) @(negedge clk);
    wait_fall(1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL shadow_sync: got timeout expected frame start");
    end
    // Write the new duty just after the frame start, then read it back
    run = 1;
    hi_seen = 1'b0;
    write = 1'b1; address = BASE + 8'd4; wdata = 8'd16;
    @(negedge clk);
    write = 1'b0; read = 1'b1;
    if (led_n[1] !== 1'b0) hi_seen = 1'b1; else run++;
    @(negedge clk);
    read = 1'b0;
    d = rdata;
    if (led_n[1] !== 1'b0) hi_seen = 1'b1; else if (!hi_seen) run++;
    m_duty[1] = 16;
    n_checks++;
    if (d !== 8'h10) begin
      n_fail++; $display("FAIL shadow_read: got %h expected 10", d);
    end
    if (!hi_seen) begin
      for (int k = 0; k < 600; k++) begin
        @(negedge clk);
        if (led_n[1] !== 1'b0) break;
        run++;
      end
    end
    n_checks++;
    if (run !== 128) begin
      n_fail++; $display("FAIL shadow_held: got %0d on cycles expected 128", run);
    end
    wait_fall(1, ok);
    run_length(1, 1'b0, run);
    n_checks++;
    if (!ok || run !== 16) begin
      n_fail++; $display("FAIL shadow_applied: got %0d on cycles (sync %0d) expected 16", run, ok);
    end
  endtask

  task automatic test_bus_rules();
    logic [7:0] d;
    int exp;
    int addrs [10];
    @(negedge clk);
    write = 1'b1; read = 1'b1; address = BASE; wdata = 8'h03;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    m_ctrl = 3;
    n_checks++;
    if (rdata !== 8'h00) begin
      n_fail++; $display("FAIL wr_rd_collision: got %h expected 00", rdata);
    end
    reg_write(127, 8'hFF);
    reg_write(200, 8'hAA);
    reg_write(int'(BASE) + 3 + CH, 8'h11);
    reg_write(int'(BASE) + 2, 8'h25);
    addrs = '{127, 128, 129, 130, 131, 132, 133, 134, 200, 255};
    foreach (addrs[k]) begin
      bus_read(8'(addrs[k]), d);
      exp = model_read(addrs[k]);
      n_checks++;
      if (d !== exp[7:0]) begin
        n_fail++; $display("FAIL bus_read[%0d]: got %h expected %h", addrs[k], d, exp[7:0]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int exp;
    reg_write(BASE + 1, 3);
    reg_write(BASE + 3, 50);
    reg_write(BASE + 4, 200);
    reg_write(BASE + 0, 7);
    repeat (1500 + $urandom_range(0, 300)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (led_n !== 3'b111) begin
      n_fail++; $display("FAIL midframe_reset_led: got %b expected %b", led_n, 3'b111);
    end
    for (int a = int'(BASE); a < int'(BASE) + 3 + CH; a++) begin
      bus_read(8'(a), d);
      exp = model_read(a);
      n_checks++;
      if (d !== exp[7:0]) begin
        n_fail++; $display("FAIL midframe_reg[%0d]: got %h expected %h", a, d, exp[7:0]);
      end
    end
    // Active duty is back to full, so the channel lights at once
    reg_write(BASE, 1);
    @(negedge clk);
    n_checks++;
    if (led_n !== 3'b110) begin
      n_fail++; $display("FAIL midframe_active: got %b expected %b", led_n, 3'b110);
    end
  endtask

  task automatic test_blink();
    bit ok;
    int run_on, run_off;
    reg_write(BASE + 1, 0);
    for (int i = 0; i < CH; i++) reg_write(int'(BASE) + 3 + i, FULL);
    reg_write(BASE + 0, 7);
    reg_write(BASE + 2, 8'h80);
    wait_fall(0, ok);
    n_checks++;
    if (led_n !== 3'b000) begin
      n_fail++; $display("FAIL blink_all_on: got %b expected %b", led_n, 3'b000);
    end
    run_length(0, 1'b0, run_on);
    run_length(0, 1'b1, run_off);
    n_checks++;
    if (!ok || run_on !== 256 || run_off !== 256) begin
      n_fail++;
      $display("FAIL blink_period: got on %0d off %0d (sync %0d) expected 256/256",
               run_on, run_off, ok);
    end
    reg_write(BASE + 2, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch, duty, p;
    rst = 1'b1; write = 1'b0; read = 1'b0; address = 8'd0; wdata = 8'd0;
    model_reset();
    test_reset();
    test_ctrl_enable();
    test_duty(0, 64, 0);
    test_duty(0, 0, 0);
    test_duty(0, FULL, 0);
    test_duty(2, 100, 3);
    repeat (4) begin
      ch   = $urandom_range(0, CH - 1);
      duty = $urandom_range(0, FULL);
      p    = $urandom_range(0, 3);
      test_duty(ch, duty, p);
    end
    test_shadow();
    test_bus_rules();
    test_reset_midframe();
    if (BLINK_BUILT) test_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_led_pwm.md
# mmio_led_pwm

Memory-mapped, parametrised LED controller on the 8-bit CPU bus. It gives each of CHANNELS active-low LED outputs an enable bit, a PWM duty register with frame-synchronous update, and a shared prescaler, plus an optional blink engine. It sits beside the CPU in the top level and decodes a small register window starting at BASE_ADDR. It is the multi-channel, dimmable generation of the single on/off LED register.

## Interface
- CHANNELS, 3: number of LED channels, 1..8
- PWM_BITS, 8: PWM counter and duty width, 1..8
- BASE_ADDR, 8'd128: first address of the register window
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- write  input  1  CPU write strobe, one cycle per access
- read  input  1  CPU read strobe, one cycle per access
- address  input  8  CPU read/write address
- wdata  input  8  write data from CPU
- rdata  output  8  read data to CPU, registered
- led_n  output  CHANNELS  LED drive, active-low (1 = off)

## Operation
- Register offsets from BASE_ADDR:
  - 0 CTRL: bits[CHANNELS-1:0] channel enable; upper bits read 0. Reset 0.
  - 1 PRESCALE: 8-bit divider. Reset 0.
  - 2 BLINK: bit7 blink enable, bits[6:0] period. Reset 0. Present only with the macro.
  - 3+i DUTY[i], i < CHANNELS: PWM_BITS duty, zero-extended on read. Reset all-ones.
- Any other address: writes are ignored and reads return 0.
- Prescaler: pre_cnt counts 0..PRESCALE. The tick pulses on the cycle pre_cnt == PRESCALE, and pre_cnt then returns to 0. PRESCALE 0 gives a tick every cycle. Writing PRESCALE clears pre_cnt.
- PWM counter: pwm_cnt (PWM_BITS) increments on each tick and wraps from all-ones to 0. That wrap cycle is the frame boundary.
- Duty shadowing:
  - A write to DUTY[i] updates only shadow[i].
  - active[i] loads shadow[i] at the frame boundary.
  - Reads of DUTY[i] return shadow[i].
  - A write on the boundary cycle is picked up at the next boundary.
- Channel on when CTRL[i] && (active[i] == all-ones || pwm_cnt < active[i]) && blink_visible.
  - Duty 0 means never on.
  - Duty all-ones means continuously on.
- led_n[i] is registered as the inverse of on.
- Bus rules:
  - A write with read also high executes the write only, and rdata is 0 next cycle.
  - Without a read, rdata returns to 0 on the next cycle.

## Timing
- Reset: led_n all 1, rdata 0, pre_cnt 0, pwm_cnt 0, CTRL 0, PRESCALE 0, shadow and active all-ones, blink phase visible, frame count 0.
- Read latency 1: rdata is valid on the cycle after read is sampled.
- Write latency: a register updates on the strobe edge. led_n reflects CTRL changes one cycle after the register updates (2 edges after the strobe).
- Duty changes reach led_n at most one full frame later: (PRESCALE+1)·2^PWM_BITS cycles + 2.
- Reset asserted mid-frame returns everything to reset values on that edge. led_n is 1 the following cycle.

## Configuration
- LED_PWM_BLINK_EN defined:
  - With BLINK bit7 = 1, frame_cnt counts frame boundaries.
  - When frame_cnt == period at a boundary, frame_cnt clears and the blink phase toggles. Period 0 toggles every frame.
  - Phase 1 forces all channels off.
  - Any BLINK write clears frame_cnt and sets phase visible.
  - With bit7 = 0, blink_visible is always 1.
- LED_PWM_BLINK_EN undefined:
  - No blink logic is built and blink_visible is constant 1.
  - Offset 2 is unmapped: writes are ignored and reads return 0.

## Test plan
- Reset, then write CTRL=8'h05 (default params, duty reset all-ones) → led_n becomes 3'b010 two edges after the strobe. Read BASE+0 → rdata 8'h05 one cycle later.
- PRESCALE=0, DUTY[0]=64, CTRL=1 → after the next frame boundary, led_n[0] is low for exactly 64 of each 256 cycles. Duty 0 → constantly high. Duty 255 → constantly low.
- Write DUTY[1]=16 mid-frame → the duty in effect is unchanged until pwm_cnt wraps, then the 16/256 pattern starts. Read BASE+4 immediately → 8'h10.
- Write and read in the same cycle to BASE+0 → CTRL updated, rdata 0. Read address 8'd200 → rdata 0. Write 8'd127 → no state change.
- PRESCALE=3 → pwm_cnt advances every 4 cycles, giving a 1024-cycle frame. Assert rst mid-frame → led_n all 1 and every register at its reset value.
- With LED_PWM_BLINK_EN, PWM_BITS=2, PRESCALE=0, BLINK=8'h81, all channels duty max → LEDs alternate 8 cycles on / 8 cycles off. Without the macro, a read of BASE+2 returns 0.
